alu_issue_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_issue_sequencer_if.sv | 34 +++
 rtl/alu_funct_decoder.sv | 31 +++
 rtl/alu_issue_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_issue_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, MIPS funct codes and issue sequencer state encoding.
package alu_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic [5:0] funct_t;

  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_XOR = 3'b010;
  localparam alu_op_t ALU_NOR = 3'b011;
  localparam alu_op_t ALU_SLT = 3'b100;
  localparam alu_op_t ALU_ADD = 3'b101;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_MOD = 3'b111;

  localparam funct_t FUNCT_MOD  = 6'h1B;
  localparam funct_t FUNCT_ADD  = 6'h20;
  localparam funct_t FUNCT_ADDU = 6'h21;
  localparam funct_t FUNCT_SUB  = 6'h22;
  localparam funct_t FUNCT_SUBU = 6'h23;
  localparam funct_t FUNCT_AND  = 6'h24;
  localparam funct_t FUNCT_OR   = 6'h25;
  localparam funct_t FUNCT_XOR  = 6'h26;
  localparam funct_t FUNCT_NOR  = 6'h27;
  localparam funct_t FUNCT_SLT  = 6'h2A;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_EXEC      = 3'd1;
  localparam logic [2:0] ST_MOD_START = 3'd2;
  localparam logic [2:0] ST_MOD_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT       = 3'd4;

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// rtl/alu_issue_sequencer_if.sv - issue, ALU-side and result handshake signals of the sequencer.
interface alu_issue_sequencer_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_c_in;
  logic             alu_reset;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_illegal;

  modport slave (
    input  in_valid, funct, rs_val, rt_val, alu_result, alu_c_out, out_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_c_in, alu_reset,
           out_valid, out_result, out_carry, out_illegal
  );

  modport master (
    output in_valid, funct, rs_val, rt_val, alu_result, alu_c_out, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_c_in, alu_reset,
           out_valid, out_result, out_carry, out_illegal
  );

endinterface

// File: rtl/alu_funct_decoder.sv
// rtl/alu_funct_decoder.sv - combinational MIPS R-type funct to 3-bit ALU opcode decode.
module alu_funct_decoder
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       is_mod,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_AND;
    is_mod  = 1'b0;
    illegal = 1'b0;
    case (funct)
      FUNCT_AND:             alu_op = ALU_AND;
      FUNCT_OR:              alu_op = ALU_OR;
      FUNCT_XOR:             alu_op = ALU_XOR;
      FUNCT_NOR:             alu_op = ALU_NOR;
      FUNCT_SLT:             alu_op = ALU_SLT;
      FUNCT_ADD, FUNCT_ADDU: alu_op = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: alu_op = ALU_SUB;
      FUNCT_MOD: begin
        alu_op = ALU_MOD;
        is_mod = 1'b1;
      end
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - issues one R-type op to the MIPS ALU, runs the MOD start/wait
// protocol and returns the captured result on a valid/ready handshake.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int MOD_CYCLES = 48,
  parameter int WIDTH      = 32
) (
  input  logic                 CLK,
  input  logic                 reset,
  alu_issue_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(MOD_CYCLES + 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] dec_op;
  logic       dec_is_mod;
  logic       dec_illegal;

  alu_funct_decoder u_decoder (
    .funct   (bus.funct),
    .alu_op  (dec_op),
    .is_mod  (dec_is_mod),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    out_result_d  = out_result_q;
    out_carry_d   = out_carry_q;
    out_illegal_d = out_illegal_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // An illegal funct leaves the ALU operands untouched so the ALU never sees it.
          if (dec_illegal) begin
            out_illegal_d = 1'b1;
            out_result_d  = '0;
            out_carry_d   = 1'b0;
            state_d       = ST_OUT;
          end else begin
            alu_a_d       = bus.rs_val;
            alu_b_d       = bus.rt_val;
            alu_op_d      = dec_op;
            out_illegal_d = 1'b0;
            state_d       = dec_is_mod ? ST_MOD_START : ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        out_result_d = bus.alu_result;
        out_carry_d  = bus.alu_c_out;
        state_d      = ST_OUT;
      end
      ST_MOD_START: begin
        cnt_d   = CNT_W'(MOD_CYCLES);
        state_d = ST_MOD_WAIT;
      end
      ST_MOD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_result_d = bus.alu_result;
          out_carry_d  = 1'b0;
          state_d      = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      out_result_q  <= '0;
      out_carry_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      out_result_q  <= out_result_d;
      out_carry_q   <= out_carry_d;
      out_illegal_q <= out_illegal_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE) && !reset;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_c_in    = 1'b0;
  assign bus.alu_reset   = reset || (state_q == ST_MOD_START);
  assign bus.out_valid   = (state_q == ST_OUT);
  assign bus.out_result  = out_result_q;
  assign bus.out_carry   = out_carry_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - scoreboard bench for alu_issue_sequencer with a behavioural MIPS ALU.
module tb_alu_issue_sequencer;
  import alu_pkg::*;

  localparam int MOD_CYCLES = 48;
  localparam int WIDTH      = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        carry;
    logic        illegal;
  } exp_t;

  logic CLK;
  logic reset;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  int   mod_cnt = 0;
  logic [32:0] alu_sum;

  alu_issue_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_issue_sequencer #(.MOD_CYCLES(MOD_CYCLES), .WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU: MOD output is garbage until MOD_CYCLES-1 cycles after the start pulse.
  always @(posedge CLK) begin
    if (bus.alu_reset) mod_cnt <= 0;
    else if (mod_cnt < 100000) mod_cnt <= mod_cnt + 1;
  end

  always_comb begin
    alu_sum        = 33'd0;
    bus.alu_result = 32'd0;
    bus.alu_c_out  = 1'b0;
    case (bus.alu_op)
      3'b000: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b010: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b011: bus.alu_result = ~(bus.alu_a | bus.alu_b);
      3'b100: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      3'b101: begin
        alu_sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = alu_sum[31:0];
        bus.alu_c_out  = alu_sum[32];
      end
      3'b110: begin
        alu_sum        = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_result = alu_sum[31:0];
        bus.alu_c_out  = alu_sum[32];
      end
      default: bus.alu_result = (mod_cnt >= MOD_CYCLES - 1 && bus.alu_b != 0)
                                ? bus.alu_a % bus.alu_b : 32'hDEAD_BEEF;
    endcase
  end

  function automatic exp_t ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = '0;
    case (f)
      6'h24: e.res = a & b;
      6'h25: e.res = a | b;
      6'h26: e.res = a ^ b;
      6'h27: e.res = ~(a | b);
      6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h20, 6'h21: begin
        e.res   = a + b;
        e.carry = (e.res < a);
      end
      6'h22, 6'h23: begin
        e.res   = a - b;
        e.carry = (a >= b);
      end
      6'h1B: e.res = a % b;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.funct    = f;
    bus.rs_val   = a;
    bus.rt_val   = b;
    sb.push_back(ref_model(f, a, b));
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.funct    = 6'h3F;
    bus.rs_val   = $urandom;
    bus.rt_val   = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!bus.out_valid && lat < 200);
  endtask

  task automatic pop_expect(output exp_t e);
    e = '1;
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.funct = 6'h0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (bus.alu_reset !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: alu_reset=%b in_ready=%b out_valid=%b required 1 0 0",
               bus.alu_reset, bus.in_ready, bus.out_valid);
    end
    n_cmp++;
    if (bus.alu_a !== 0 || bus.alu_b !== 0 || bus.alu_op !== 0 || bus.alu_c_in !== 0) begin
      n_bad++;
      $display("FAIL reset_alu: a=%0h b=%0h op=%0b cin=%b required all 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c_in);
    end
    n_cmp++;
    if (bus.out_result !== 0 || bus.out_carry !== 0 || bus.out_illegal !== 0) begin
      n_bad++;
      $display("FAIL reset_out: result=%0h carry=%b illegal=%b required all 0",
               bus.out_result, bus.out_carry, bus.out_illegal);
    end
    reset = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.alu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b alu_reset=%b required 1 0", bus.in_ready, bus.alu_reset);
    end
  endtask

  task automatic test_and();
    exp_t e;
    int   lat;
    bit   busy_ok;
    issue(6'h24, 32'd12112455, 32'd232112352);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge CLK);
      lat++;
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    end while (!bus.out_valid && lat < 200);
    pop_expect(e);
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL and_latency: got %0d required 2", lat); end
    n_cmp++;
    if (bus.alu_op !== ALU_AND) begin n_bad++; $display("FAIL and_op: got %0b required 000", bus.alu_op); end
    n_cmp++;
    if (!busy_ok) begin n_bad++; $display("FAIL and_in_ready_busy: in_ready high in cycles 1-2, required low"); end
    n_cmp++;
    if (bus.out_result !== e.res || bus.out_carry !== e.carry) begin
      n_bad++;
      $display("FAIL and_result: got %0h/%b required %0h/%b", bus.out_result, bus.out_carry, e.res, e.carry);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL and_idle: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_slt();
    exp_t        e;
    int          lat;
    logic [31:0] av [2] = '{32'd15, 32'd12};
    logic [31:0] bv [2] = '{32'd12, 32'd15};
    logic        want [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      issue(6'h2A, av[i], bv[i]);
      wait_valid(lat);
      pop_expect(e);
      n_cmp++;
      if (lat != 2 || bus.out_result[0] !== want[i] || bus.out_result !== e.res) begin
        n_bad++;
        $display("FAIL slt_%0d: lat=%0d result=%0h required lat 2 result %0h", i, lat, bus.out_result, e.res);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_add_sub();
    exp_t        e;
    int          lat;
    logic [5:0]  fv [3] = '{6'h20, 6'h22, 6'h21};
    logic [31:0] av [3] = '{32'd15, 32'd15, 32'hFFFF_FFF0};
    logic [31:0] rv [3] = '{32'd27, 32'd3, 32'd4};
    logic [31:0] bv [3];
    bv[0] = 32'd12;
    bv[1] = 32'd12;
    bv[2] = 32'h14;
    for (int i = 0; i < 3; i++) begin
      issue(fv[i], av[i], bv[i]);
      wait_valid(lat);
      pop_expect(e);
      n_cmp++;
      if (lat != 2 || bus.out_result !== rv[i] || bus.out_result !== e.res) begin
        n_bad++;
        $display("FAIL addsub_%0d_result: lat=%0d got %0h required lat 2 result %0h", i, lat, bus.out_result, rv[i]);
      end
      n_cmp++;
      if (bus.out_carry !== e.carry) begin
        n_bad++;
        $display("FAIL addsub_%0d_carry: got %b required %b", i, bus.out_carry, e.carry);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_mod();
    exp_t e;
    int   lat;
    int   rst_cycles;
    int   first_rst;
    bit   ops_ok;
    issue(6'h1B, 32'd15, 32'd6);
    lat = 0;
    rst_cycles = 0;
    first_rst = -1;
    ops_ok = 1'b1;
    do begin
      @(negedge CLK);
      lat++;
      if (bus.alu_reset) begin
        rst_cycles++;
        if (first_rst < 0) first_rst = lat;
      end
      if (bus.alu_a !== 32'd15 || bus.alu_b !== 32'd6) ops_ok = 1'b0;
    end while (!bus.out_valid && lat < 200);
    pop_expect(e);
    n_cmp++;
    if (lat != MOD_CYCLES + 2) begin n_bad++; $display("FAIL mod_latency: got %0d required %0d", lat, MOD_CYCLES + 2); end
    n_cmp++;
    if (rst_cycles != 1 || first_rst != 1) begin
      n_bad++;
      $display("FAIL mod_start_pulse: %0d cycles first at %0d required 1 cycle at 1", rst_cycles, first_rst);
    end
    n_cmp++;
    if (!ops_ok) begin n_bad++; $display("FAIL mod_operands: alu_a/alu_b moved, required 15/6 throughout"); end
    n_cmp++;
    if (bus.out_result !== e.res || bus.out_carry !== 1'b0 || bus.alu_op !== ALU_MOD) begin
      n_bad++;
      $display("FAIL mod_result: got %0h carry %b op %0b required %0h 0 111",
               bus.out_result, bus.out_carry, bus.alu_op, e.res);
    end
    @(negedge CLK);
  endtask

  task automatic test_illegal_backpressure();
    exp_t e;
    int   lat;
    bit   stable_ok;
    bus.out_ready = 1'b0;
    issue(6'h3F, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_valid(lat);
    pop_expect(e);
    n_cmp++;
    if (lat != 1) begin n_bad++; $display("FAIL illegal_latency: got %0d required 1", lat); end
    n_cmp++;
    if (bus.out_illegal !== e.illegal || bus.out_result !== e.res || bus.out_carry !== e.carry) begin
      n_bad++;
      $display("FAIL illegal_out: illegal=%b result=%0h carry=%b required %b %0h %b",
               bus.out_illegal, bus.out_result, bus.out_carry, e.illegal, e.res, e.carry);
    end
    n_cmp++;
    if (bus.alu_op !== ALU_MOD || bus.alu_a !== 32'd15 || bus.alu_b !== 32'd6) begin
      n_bad++;
      $display("FAIL illegal_alu_kept: op=%0b a=%0h b=%0h required 111 f 6", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    stable_ok = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'd0 ||
          bus.out_carry !== 1'b0 || bus.in_ready !== 1'b0) stable_ok = 1'b0;
    end
    n_cmp++;
    if (!stable_ok) begin n_bad++; $display("FAIL backpressure_hold: outputs changed while out_ready=0"); end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_mod();
    exp_t e;
    int   lat;
    bit   quiet;
    issue(6'h1B, 32'd20, 32'd7);
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (bus.alu_reset !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_wait: alu_reset=%b out_valid=%b required 0 0", bus.alu_reset, bus.out_valid);
    end
    reset = 1'b1;
    @(negedge CLK);
    sb.delete();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.alu_a !== 0 || bus.alu_op !== 0 || bus.alu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_state: out_valid=%b a=%0h op=%0b alu_reset=%b required 0 0 0 1",
               bus.out_valid, bus.alu_a, bus.alu_op, bus.alu_reset);
    end
    reset = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.alu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_release: in_ready=%b alu_reset=%b required 1 0", bus.in_ready, bus.alu_reset);
    end
    quiet = 1'b1;
    repeat (MOD_CYCLES + 5) begin
      @(negedge CLK);
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL midreset_discard: out_valid rose after reset, required none"); end
    issue(6'h20, 32'd100, 32'd23);
    wait_valid(lat);
    pop_expect(e);
    n_cmp++;
    if (lat != 2 || bus.out_result !== e.res || bus.out_illegal !== 1'b0 || bus.out_carry !== e.carry) begin
      n_bad++;
      $display("FAIL midreset_fresh_add: lat=%0d result=%0h illegal=%b required lat 2 %0h 0",
               lat, bus.out_result, bus.out_illegal, e.res);
    end
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_and();
    test_slt();
    test_add_sub();
    test_mod();
    test_illegal_backpressure();
    test_reset_mid_mod();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
